// File: rtl/ps2_pkg.sv
// Shared encodings for the PS/2 key sequencer: FSM states, scan-code constants, event layout.
package ps2_pkg;

  typedef enum logic [1:0] {FWait, FPop, FGap} fetch_state_e;
  typedef enum logic [1:0] {PIdle, PE0, PF0, PE0F0} parse_state_e;

  localparam logic [7:0] ScExt    = 8'hE0;
  localparam logic [7:0] ScBrk    = 8'hF0;
  localparam logic [7:0] ScLShift = 8'h12;
  localparam logic [7:0] ScRShift = 8'h59;
  localparam logic [7:0] ScCtrl   = 8'h14;
  localparam logic [7:0] ScCaps   = 8'h58;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } key_evt_t;

  localparam int unsigned EvtW = 10;

  // Press counter runs 0..99 and wraps.
  function automatic logic [7:0] count_inc(input logic [7:0] c);
    return (c >= 8'd99) ? 8'd0 : c + 8'd1;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Key event queue of QDEPTH 10-bit entries; a push into a full queue is taken when a pop
// happens in the same cycle.
module key_evt_fifo #(
  parameter int unsigned QDEPTH = 4
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       push,
  input  logic [9:0] wdata,
  input  logic       pop,
  output logic [9:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam logic [AW:0] PtrOne = 1;

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [9:0]  mem_q [QDEPTH];
  logic        do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Pops PS/2 scan bytes, folds E0/F0 prefixes into key events, tracks modifiers and presses.
// Define REPEAT_FILTER_EN to drop typematic repeat makes from the event stream.
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ready,
  input  logic [7:0] data,
  output logic       nextdata_n,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       shift_on,
  output logic       ctrl_on,
  output logic       caps_lock,
  output logic [7:0] press_count
);

  fetch_state_e    fstate_q;
  parse_state_e    pstate_q, pstate_d;
  logic [7:0]      byte_q;
  logic            byte_vld_q;
  logic [8:0]      held_q;
  logic            held_vld_q;
  logic            lshift_q, rshift_q, caps_held_q;
  logic            is_code, is_make, is_brk, non_repeat, push;
  key_evt_t        evt_d, evt_head;
  logic [EvtW-1:0] head_bits;
  logic            q_full, q_empty;

  // Fetch: one pop strobe per byte, then a dead cycle so the receiver head can settle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      fstate_q   <= FWait;
      nextdata_n <= 1'b1;
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
    end else begin
      nextdata_n <= 1'b1;
      byte_vld_q <= 1'b0;
      case (fstate_q)
        FWait: begin
          if (ready && !q_full) begin
            fstate_q   <= FPop;
            nextdata_n <= 1'b0;
          end
        end
        FPop: begin
          byte_q     <= data;
          byte_vld_q <= 1'b1;
          fstate_q   <= FGap;
        end
        FGap:    fstate_q <= FWait;
        default: fstate_q <= FWait;
      endcase
    end
  end

  always_comb begin
    pstate_d = pstate_q;
    is_code  = 1'b0;
    if (byte_vld_q) begin
      if (byte_q == ScExt) begin
        pstate_d = (pstate_q == PIdle) ? PE0 : PIdle;
      end else if (byte_q == ScBrk) begin
        case (pstate_q)
          PIdle:   pstate_d = PF0;
          PE0:     pstate_d = PE0F0;
          default: pstate_d = PIdle;
        endcase
      end else begin
        is_code  = 1'b1;
        pstate_d = PIdle;
      end
    end
    evt_d.code = byte_q;
    evt_d.ext  = (pstate_q == PE0) || (pstate_q == PE0F0);
    evt_d.brk  = (pstate_q == PF0) || (pstate_q == PE0F0);
    is_make    = is_code && !evt_d.brk;
    is_brk     = is_code && evt_d.brk;
    non_repeat = is_make && (!held_vld_q || (held_q != {evt_d.ext, evt_d.code}));
`ifdef REPEAT_FILTER_EN
    push = is_brk || non_repeat;
`else
    push = is_code;
`endif
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pstate_q    <= PIdle;
      held_q      <= '0;
      held_vld_q  <= 1'b0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      ctrl_on     <= 1'b0;
      caps_lock   <= 1'b0;
      caps_held_q <= 1'b0;
      press_count <= '0;
    end else begin
      pstate_q <= pstate_d;
      if (is_make) begin
        held_q     <= {evt_d.ext, evt_d.code};
        held_vld_q <= 1'b1;
      end else if (is_brk && (held_q == {evt_d.ext, evt_d.code})) begin
        held_vld_q <= 1'b0;
      end
      if (non_repeat) press_count <= count_inc(press_count);
      // E0-prefixed 12/58 are fake keys in print-screen sequences, not shift or caps.
      if (is_code && !evt_d.ext) begin
        if (evt_d.code == ScLShift) lshift_q <= is_make;
        if (evt_d.code == ScRShift) rshift_q <= is_make;
        if (evt_d.code == ScCaps) begin
          if (is_make && !caps_held_q) caps_lock <= !caps_lock;
          caps_held_q <= is_make;
        end
      end
      if (is_code && (evt_d.code == ScCtrl)) ctrl_on <= is_make;
    end
  end

  assign shift_on = lshift_q | rshift_q;

  key_evt_fifo #(
    .QDEPTH(QDEPTH)
  ) u_evt_fifo (
    .clk  (clk),
    .clrn (clrn),
    .push (push),
    .wdata(evt_d),
    .pop  (evt_ready),
    .rdata(head_bits),
    .full (q_full),
    .empty(q_empty)
  );

  assign evt_head  = key_evt_t'(head_bits);
  assign evt_valid = !q_empty;
  assign evt_code  = evt_valid ? evt_head.code : 8'h00;
  assign evt_ext   = evt_valid & evt_head.ext;
  assign evt_break = evt_valid & evt_head.brk;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer: receiver FIFO model plus event scoreboard.
module tb_ps2_key_sequencer;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] data = 8'h00;
  logic       evt_ready = 1'b0;
  logic       nextdata_n, evt_valid, evt_ext, evt_break, shift_on, ctrl_on, caps_lock;
  logic [7:0] evt_code, press_count;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  ps2_q[$];
  logic [11:0] exp_q[$];   // {check_shift, shift, code, ext, brk}
  logic [11:0] mon_e;
  logic [7:0]  dropped;
  int          pulses = 0;
  int          hi_run = 0;
  bit          lo_prev = 1'b0;
  int          exp_count = 0;
  int          p0;

  always #5 clk = ~clk;

  ps2_key_sequencer #(
    .QDEPTH(4)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ready      (ready),
    .data       (data),
    .nextdata_n (nextdata_n),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_code   (evt_code),
    .evt_ext    (evt_ext),
    .evt_break  (evt_break),
    .shift_on   (shift_on),
    .ctrl_on    (ctrl_on),
    .caps_lock  (caps_lock),
    .press_count(press_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    ps2_q.push_back(b);
  endtask

  task automatic expect_evt(input logic [7:0] code, input logic ext, input logic brk,
                            input logic chk_sh, input logic sh);
    exp_q.push_back({chk_sh, sh, code, ext, brk});
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || ps2_q.size() != 0) && n < 5000) begin
      tick(1);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    tick(10);
  endtask

  task automatic check_reset();
    chk("rst_nextdata_n", 32'(nextdata_n), 32'd1);
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_evt_code", 32'(evt_code), 32'd0);
    chk("rst_evt_ext", 32'(evt_ext), 32'd0);
    chk("rst_evt_break", 32'(evt_break), 32'd0);
    chk("rst_shift_on", 32'(shift_on), 32'd0);
    chk("rst_ctrl_on", 32'(ctrl_on), 32'd0);
    chk("rst_caps_lock", 32'(caps_lock), 32'd0);
    chk("rst_press_count", 32'(press_count), 32'd0);
  endtask

  // Receiver FIFO model: head presented away from the edge, popped on a low strobe.
  always @(negedge clk) begin
    ready = (ps2_q.size() != 0);
    data  = (ps2_q.size() != 0) ? ps2_q[0] : 8'h00;
  end

  always @(posedge clk) begin
    if (clrn && !nextdata_n && ps2_q.size() != 0) dropped = ps2_q.pop_front();
  end

  // Strobe shape and event scoreboard.
  always @(negedge clk) begin
    if (clrn) begin
      if (!nextdata_n) begin
        chk("pop_width", 32'(lo_prev), 32'd0);
        if (!lo_prev) begin
          if (pulses > 0) chk("pop_gap", 32'(hi_run >= 2), 32'd1);
          pulses++;
        end
        hi_run  = 0;
        lo_prev = 1'b1;
      end else begin
        hi_run++;
        lo_prev = 1'b0;
      end
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          chk("evt_extra", 32'({evt_code, evt_ext, evt_break}), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("evt", 32'({evt_code, evt_ext, evt_break}), 32'(mon_e[9:0]));
          if (mon_e[11]) chk("shift_at_evt", 32'(shift_on), 32'(mon_e[10]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached before finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check_reset();
    clrn = 1'b1;
    evt_ready = 1'b1;
    tick(2);

    // Plain make/break with strobe shape.
    p0 = pulses;
    send(8'h1C); send(8'hF0); send(8'h1C);
    expect_evt(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_evt(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_count++;
    drain();
    chk("s1_pulses", 32'(pulses - p0), 32'd3);
    chk("s1_press_count", 32'(press_count), 32'(exp_count));

    // Extended make/break; prefixes produce nothing.
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    expect_evt(8'h75, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_evt(8'h75, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_count++;
    drain();
    chk("s2_press_count", 32'(press_count), 32'(exp_count));

    // Extended ctrl make/break.
    send(8'hE0); send(8'h14);
    expect_evt(8'h14, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_count++;
    drain();
    chk("ctrl_make", 32'(ctrl_on), 32'd1);
    send(8'hE0); send(8'hF0); send(8'h14);
    expect_evt(8'h14, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    chk("ctrl_break", 32'(ctrl_on), 32'd0);

    // Shift held across a typematic 1C.
    send(8'h12); send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    expect_evt(8'h12, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_evt(8'h1C, 1'b0, 1'b0, 1'b1, 1'b1);
`ifndef REPEAT_FILTER_EN
    expect_evt(8'h1C, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_evt(8'h1C, 1'b0, 1'b0, 1'b1, 1'b1);
`endif
    expect_evt(8'h1C, 1'b0, 1'b1, 1'b1, 1'b1);
    expect_evt(8'h12, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_count += 2;
    drain();
    chk("s3_press_count", 32'(press_count), 32'(exp_count));
    chk("s3_shift_off", 32'(shift_on), 32'd0);

    // Backpressure: only four events fit, the rest wait in the receiver.
    evt_ready = 1'b0;
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24); send(8'h2B);
    expect_evt(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_evt(8'h32, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_evt(8'h21, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_evt(8'h23, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_evt(8'h24, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_evt(8'h2B, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_count += 6;
    p0 = pulses;
    tick(60);
    chk("bp_pops", 32'(pulses - p0), 32'd4);
    chk("bp_bytes_left", 32'(ps2_q.size()), 32'd2);
    chk("bp_evt_valid", 32'(evt_valid), 32'd1);
    chk("bp_evt_code", 32'(evt_code), 32'h1C);
    p0 = pulses;
    tick(20);
    chk("bp_no_pop", 32'(pulses - p0), 32'd0);
    chk("bp_nextdata_n", 32'(nextdata_n), 32'd1);
    evt_ready = 1'b1;
    drain();
    chk("bp_press_count", 32'(press_count), 32'(exp_count));

    // Caps lock toggles once per physical press.
    send(8'h58);
    expect_evt(8'h58, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_count++;
    drain();
    chk("caps_1", 32'(caps_lock), 32'd1);
    send(8'hF0); send(8'h58);
    expect_evt(8'h58, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();
    chk("caps_2", 32'(caps_lock), 32'd1);
    send(8'h58);
    expect_evt(8'h58, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_count++;
    drain();
    chk("caps_3", 32'(caps_lock), 32'd0);
    send(8'h58);
`ifndef REPEAT_FILTER_EN
    expect_evt(8'h58, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    drain();
    chk("caps_repeat", 32'(caps_lock), 32'd0);
    chk("caps_repeat_count", 32'(press_count), 32'(exp_count));
    send(8'hF0); send(8'h58);
    expect_evt(8'h58, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();

    // Walk the press counter to 99, then wrap.
    while (exp_count != 99) begin
      send(8'h1C); send(8'hF0); send(8'h1C);
      expect_evt(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_evt(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
      exp_count++;
    end
    drain();
    chk("count_99", 32'(press_count), 32'd99);
    send(8'h1C); send(8'hF0); send(8'h1C);
    expect_evt(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_evt(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_count = 0;
    drain();
    chk("count_wrap", 32'(press_count), 32'(exp_count));

    // Reset in the middle of an E0 F0 prefix, with events still queued.
    evt_ready = 1'b0;
    send(8'h14); send(8'h58); send(8'hE0); send(8'hF0);
    exp_count += 2;
    for (int i = 0; i < 200 && ps2_q.size() != 0; i++) tick(1);
    tick(10);
    chk("pre_rst_evt_valid", 32'(evt_valid), 32'd1);
    chk("pre_rst_ctrl", 32'(ctrl_on), 32'd1);
    chk("pre_rst_caps", 32'(caps_lock), 32'd1);
    chk("pre_rst_count", 32'(press_count), 32'(exp_count));
    clrn = 1'b0;
    #1;
    check_reset();
    tick(2);
    clrn = 1'b1;
    evt_ready = 1'b1;
    tick(1);
    send(8'h1C);
    expect_evt(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_count = 1;
    drain();
    chk("post_rst_count", 32'(press_count), 32'(exp_count));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
